// File: rtl/des_pkg.sv
// Shared DES S-box definitions: widths, FSM state type and the eight FIPS 46-3
// substitution tables. Each table holds 64 nibbles, row-major, entry 0 in the MSBs.
package des_pkg;

  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int NUM_SBOX   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Row is the outer bit pair {a,f}, column the inner four bits {b,c,d,e}.
  function automatic logic [SBOX_OUT_W-1:0] sbox_lookup(input logic [2:0] box_idx,
                                                        input logic [SBOX_IN_W-1:0] six);
    logic [255:0] tbl;
    logic [5:0]   idx;
    logic [7:0]   base;
    idx = {six[5], six[0], six[4:1]};
    case (box_idx)
      3'd0: tbl = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                   64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
      3'd1: tbl = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                   64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
      3'd2: tbl = {64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
                   64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
      3'd3: tbl = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                   64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
      3'd4: tbl = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                   64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
      3'd5: tbl = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                   64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
      3'd6: tbl = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                   64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
      3'd7: tbl = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                   64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
      default: tbl = '0;
    endcase
    base = 8'd255 - {idx, 2'b00};
    return tbl[base -: 4];
  endfunction

endpackage

// File: rtl/des_sbox_seq_lut.sv
// One combinational S-box lane; the box number is a run-time input so a lane
// can serve a different box on every step.
module sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]            box_idx,
  input  logic [SBOX_IN_W-1:0]  six,
  output logic [SBOX_OUT_W-1:0] dout
);

  assign dout = sbox_lookup(box_idx, six);

endmodule

// File: rtl/des_sbox_seq.sv
// Sequential DES S-box stage: LANES lookups per cycle over STEPS cycles, results
// gathered MSB-first in an accumulator that doubles as the output register.
module des_sbox_seq
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int STEPS  = NUM_SBOX / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LW     = LANES * SBOX_OUT_W;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end

  state_t            state;
  state_t            state_next;
  logic [STEP_W-1:0] step;
  logic [47:0]       hold;
  logic [31:0]       acc;
  logic [LW-1:0]     lane_bits;
  logic              accept;
  logic              last_step;

  // The holding register shifts left each step, so lane l always reads a fixed slice.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2:0] box;
    assign box = 3'(32'(step) * LANES + l);
    sbox_lut u_lut (
      .box_idx (box),
      .six     (hold[47-6*l -: 6]),
      .dout    (lane_bits[LW-1-4*l -: 4])
    );
  end

  assign last_step = (step == STEP_W'(STEPS - 1));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);
  assign out_data  = acc;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_BUSY;
        else          state_next = ST_IDLE;
      end
      ST_BUSY: begin
        if (last_step) state_next = ST_DONE;
        else           state_next = ST_BUSY;
      end
      ST_DONE: begin
        // Pass-through: a consumer draining the result frees the unit this cycle.
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? ST_BUSY : ST_IDLE;
        else           state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      step  <= '0;
      hold  <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        hold <= in_data;
        step <= '0;
      end else if (state == ST_BUSY) begin
        hold <= hold << (6 * LANES);
        step <= step + STEP_W'(1);
        acc  <= (acc << LW) | 32'(lane_bits);
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed bench for des_sbox_seq: four instances (LANES 1, 2, 4, 8) share one
// stimulus stream and are checked in lockstep against hand-computed vectors.
module tb_des_sbox_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_data;
  logic [3:0]  in_ready_v;
  logic [3:0]  out_valid_v;
  logic [3:0]  busy_v;
  logic [31:0] out_data_v [4];

  int passed = 0;
  int total  = 0;
  int lat [4];
  logic [3:0] rdy_at0;
  logic [3:0] busy_at1;

  localparam int EXP_LAT [4] = '{9, 5, 3, 2};

  // Independent copy of the FIPS 46-3 tables: 32 rows of 16 nibbles, box-major.
  localparam logic [63:0] TB_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  des_sbox_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_data(out_data_v[0]), .busy(busy_v[0]));
  des_sbox_seq #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_data(out_data_v[1]), .busy(busy_v[1]));
  des_sbox_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_data(out_data_v[2]), .busy(busy_v[2]));
  des_sbox_seq #(.LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .in_data(in_data), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .out_data(out_data_v[3]), .busy(busy_v[3]));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [47:0] d);
    logic [31:0] res;
    logic [5:0]  g;
    logic [63:0] r;
    int          row;
    int          col;
    res = 32'd0;
    for (int b = 0; b < 8; b++) begin
      g   = d[47-6*b -: 6];
      row = int'({g[5], g[0]});
      col = int'(g[4:1]);
      r   = TB_ROWS[b*4 + row];
      res = {res[27:0], r[63-4*col -: 4]};
    end
    return res;
  endfunction

  // Presents one word (optionally consuming the pending result in the same cycle)
  // and records per-instance latency, counted from the presenting cycle.
  task automatic run_word(input logic [47:0] d, input logic consume, input logic noise);
    int cyc;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = consume;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    #1 rdy_at0 = in_ready_v;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy_at1 = busy_v;
      in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 48'({$urandom(), $urandom()});
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
        if (out_valid_v[k] && lat[k] == 0) lat[k] = cyc;
    end while (out_valid_v != 4'hF && cyc < 40);
    in_valid = 1'b0;
    if (out_valid_v != 4'hF) begin
      total++;
      $display("FAIL timeout: out_valid=%b after %0d cycles, required 1111", out_valid_v, cyc);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 48'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({in_ready_v[k], out_valid_v[k], busy_v[k], out_data_v[k]} !== {3'b100, 32'd0})
        $display("FAIL reset[%0d]: rdy/vld/busy=%b%b%b data=%h, required 100 00000000",
                 k, in_ready_v[k], out_valid_v[k], busy_v[k], out_data_v[k]);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_zero_word();
    run_word(48'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data_v[k] !== 32'hEFA72C4D)
        $display("FAIL zero_data[%0d]: got %h, required efa72c4d", k, out_data_v[k]);
      else passed++;
      total++;
      if (lat[k] != EXP_LAT[k])
        $display("FAIL zero_latency[%0d]: got %0d, required %0d", k, lat[k], EXP_LAT[k]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_ones_and_single();
    run_word(48'hFFFFFFFFFFFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data_v[k] !== 32'hD9CE3DCB)
        $display("FAIL ones_data[%0d]: got %h, required d9ce3dcb", k, out_data_v[k]);
      else passed++;
    end
    drain();
    // S1 group 000001 selects row 1, column 0 -> 0; other boxes see row 0, column 0.
    run_word(48'h040000000000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data_v[k] !== 32'h0FA72C4D)
        $display("FAIL s1_single[%0d]: got %h, required 0fa72c4d", k, out_data_v[k]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_hold();
    logic ok;
    run_word(48'h6117BA866527, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data_v[k] !== 32'h5C82B597)
        $display("FAIL des_vector[%0d]: got %h, required 5c82b597", k, out_data_v[k]);
      else passed++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = 48'({$urandom(), $urandom()});
      out_ready = 1'b0;
      #1;
      ok = ({out_valid_v, in_ready_v} === 8'hF0);
      for (int k = 0; k < 4; k++) ok = ok && (out_data_v[k] === 32'h5C82B597);
      total++;
      if (!ok)
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b data0=%h data3=%h, required 1111 0000 5c82b597",
                 i, out_valid_v, in_ready_v, out_data_v[0], out_data_v[3]);
      else passed++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    run_word(48'h6117BA866527, 1'b0, 1'b0);
    run_word(48'h0, 1'b1, 1'b0);
    total++;
    if (rdy_at0 !== 4'hF)
      $display("FAIL b2b_in_ready: got %b, required 1111", rdy_at0);
    else passed++;
    total++;
    if (busy_at1 !== 4'hF)
      $display("FAIL b2b_busy_next: got %b, required 1111", busy_at1);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data_v[k] !== 32'hEFA72C4D || lat[k] != EXP_LAT[k])
        $display("FAIL b2b_second[%0d]: data %h lat %0d, required efa72c4d lat %0d",
                 k, out_data_v[k], lat[k], EXP_LAT[k]);
      else passed++;
    end
    drain();
    repeat (3) @(negedge clk);
    total++;
    if (out_valid_v !== 4'h0 || in_ready_v !== 4'hF)
      $display("FAIL b2b_no_duplicate: vld=%b rdy=%b, required 0000 1111", out_valid_v, in_ready_v);
    else passed++;
  endtask

  task automatic test_reset_mid_busy();
    in_data  = 48'h6117BA866527;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy_v[0] !== 1'b1)
      $display("FAIL midbusy_pre: busy(L1)=%b, required 1", busy_v[0]);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({in_ready_v, out_valid_v, busy_v} !== 12'hF00)
      $display("FAIL midbusy_state: rdy=%b vld=%b busy=%b, required 1111 0000 0000",
               in_ready_v, out_valid_v, busy_v);
    else passed++;
    total++;
    if (out_data_v[0] !== 32'd0 || out_data_v[3] !== 32'd0)
      $display("FAIL midbusy_data: got %h/%h, required 00000000", out_data_v[0], out_data_v[3]);
    else passed++;
    @(negedge clk);
    run_word(48'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data_v[k] !== 32'hEFA72C4D || lat[k] != EXP_LAT[k])
        $display("FAIL midbusy_after[%0d]: data %h lat %0d, required efa72c4d lat %0d",
                 k, out_data_v[k], lat[k], EXP_LAT[k]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_random();
    logic [47:0] w;
    logic [31:0] exp_data;
    logic        b2b;
    for (int i = 0; i < 40; i++) begin
      w   = 48'({$urandom(), $urandom()});
      b2b = (i > 0) && ($urandom_range(0, 1) == 1);
      if (!b2b) begin
        if (i > 0) drain();
        repeat ($urandom_range(0, 2)) begin
          in_data = 48'({$urandom(), $urandom()});
          @(negedge clk);
        end
      end
      run_word(w, b2b, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_data = ref_model(w);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (out_data_v[k] !== exp_data || lat[k] != EXP_LAT[k])
          $display("FAIL random%0d[%0d]: in %h data %h lat %0d, required %h lat %0d",
                   i, k, w, out_data_v[k], lat[k], exp_data, EXP_LAT[k]);
        else passed++;
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_zero_word();
    test_ones_and_single();
    test_hold();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
